// File: rtl/qdec_cabac_package.sv
// rtl/qdec_cabac_package.sv - shared CABAC types and context tables for MVD syntax decoding
package qdec_cabac_package;

  typedef enum logic [3:0] {
    IDLE_MVD, GT0_X, GT0_Y, GT1_X, GT1_Y,
    EGP_X, EGS_X, SIGN_X, EGP_Y, EGS_Y, SIGN_Y, DONE_MVD
  } t_state_mvd;

  localparam logic [1:0] SLICE_B = 2'd0;
  localparam logic [1:0] SLICE_P = 2'd1;

  localparam int EG_ACC_W = 17;

  // Indexed by initType-1
  localparam logic [9:0] CTXIDX_ABS_MVD_GT0 [2] = '{10'd40, 10'd41};
  localparam logic [9:0] CTXIDX_ABS_MVD_GT1 [2] = '{10'd42, 10'd43};

  // Returns initType-1: P uses set 1 unless swapped, B (and anything else) uses set 2
  function automatic logic init_set(input logic [1:0] slice_type, input logic cabac_init_flag);
    case (slice_type)
      SLICE_P: return cabac_init_flag;
      SLICE_B: return !cabac_init_flag;
      default: return !cabac_init_flag;
    endcase
  endfunction

endpackage

// File: rtl/qdec_eg1_accum.sv
// rtl/qdec_eg1_accum.sv - EG1 prefix/suffix accumulator for abs_mvd_minus2
module qdec_eg1_accum
  import qdec_cabac_package::*;
#(
  parameter int EG_MAX_PREFIX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                bin,
  input  logic                bin_vld,
  input  logic                phase,
  output logic                prefix_done,
  output logic                suffix_done,
  output logic [EG_ACC_W-1:0] value,
  output logic                overflow
);

  localparam logic [EG_ACC_W-1:0] ACC_ONE = {{(EG_ACC_W-1){1'b0}}, 1'b1};

  logic [4:0]          r_k;
  logic [4:0]          r_rem;
  logic [EG_ACC_W-1:0] r_val;
  logic                w_pre_bin;
  logic                w_suf_bin;

  assign w_pre_bin   = bin_vld && !phase;
  assign w_suf_bin   = bin_vld && phase;
  // k equals one plus the prefix ones seen, so k hitting the limit means this one is one too many
  assign overflow    = w_pre_bin && bin && (r_k == 5'(EG_MAX_PREFIX));
  assign prefix_done = w_pre_bin && !bin;
  assign suffix_done = w_suf_bin && (r_rem == 5'd1);
  assign value       = r_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k   <= 5'd1;
      r_rem <= 5'd0;
      r_val <= '0;
    end else if (clear) begin
      r_k   <= 5'd1;
      r_rem <= 5'd0;
      r_val <= '0;
    end else if (w_pre_bin) begin
      if (bin && !overflow) begin
        r_val <= r_val + (ACC_ONE << r_k);
        r_k   <= r_k + 5'd1;
      end else if (!bin) begin
        r_rem <= r_k;
      end
    end else if (w_suf_bin) begin
      if (bin) r_val <= r_val + (ACC_ONE << (r_rem - 5'd1));
      r_rem <= r_rem - 5'd1;
    end
  end

endmodule

// File: rtl/qdec_mvd_syntax_fsm.sv
// rtl/qdec_mvd_syntax_fsm.sv - mvd_coding() bin-serial syntax decoder driving the shared CABAC engine
module qdec_mvd_syntax_fsm
  import qdec_cabac_package::*;
#(
  parameter int MVD_W         = 16,
  parameter int EG_MAX_PREFIX = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mvd_start,
  input  logic [1:0]              slice_type,
  input  logic                    cabac_init_flag,
  output logic [9:0]              ctx_mvd_addr,
  output logic                    ctx_mvd_addr_vld,
  output logic                    dec_run_mvd,
  input  logic                    dec_rdy,
  output logic                    EPMode_mvd,
  input  logic                    ruiBin,
  input  logic                    ruiBin_vld,
  output logic signed [MVD_W-1:0] mvd_x,
  output logic signed [MVD_W-1:0] mvd_y,
  output logic                    mvd_err,
  output logic                    mvd_done_intr
);

  t_state_mvd r_state, w_next;
  logic r_pending, r_init_idx, r_gt0_x, r_gt0_y, r_gt1_x, r_gt1_y, r_err;
  logic signed [MVD_W-1:0] r_mvd_x, r_mvd_y;
  logic w_bin_state, w_regular, w_issue, w_consume, w_start_acc;
  logic w_set_x, w_set_y, w_err_set;
  logic w_eg_vld, w_eg_phase, w_eg_clear, w_pre_done, w_suf_done, w_ovf;
  logic [9:0]          w_ctx;
  logic [EG_ACC_W-1:0] w_eg_val, w_abs_x, w_abs_y;

  function automatic logic [MVD_W-1:0] sat_mvd(input logic [EG_ACC_W-1:0] abs_v, input logic neg);
    logic [31:0] a, lim;
    a   = 32'(abs_v);
    lim = 32'd1 << (MVD_W - 1);
    if (a >= lim) return neg ? lim[MVD_W-1:0] : MVD_W'(lim - 32'd1);
    return neg ? MVD_W'(32'd0 - a) : a[MVD_W-1:0];
  endfunction

  assign w_start_acc = (r_state == IDLE_MVD) && mvd_start;
  assign w_consume   = ruiBin_vld && r_pending;
  assign w_issue     = w_bin_state && !r_pending && dec_rdy;
  assign w_eg_vld    = w_consume && (r_state inside {EGP_X, EGS_X, EGP_Y, EGS_Y});
  assign w_eg_phase  = (r_state == EGS_X) || (r_state == EGS_Y);
  // One accumulator serves both components; it restarts once x has been committed
  assign w_eg_clear  = w_start_acc || w_set_x;
  assign w_abs_x     = r_gt1_x ? w_eg_val + EG_ACC_W'(2) : EG_ACC_W'(1);
  assign w_abs_y     = r_gt1_y ? w_eg_val + EG_ACC_W'(2) : EG_ACC_W'(1);

  qdec_eg1_accum #(.EG_MAX_PREFIX(EG_MAX_PREFIX)) u_eg1 (
    .clk(clk), .rst_n(rst_n), .clear(w_eg_clear), .bin(ruiBin), .bin_vld(w_eg_vld),
    .phase(w_eg_phase), .prefix_done(w_pre_done), .suffix_done(w_suf_done),
    .value(w_eg_val), .overflow(w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE_MVD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_bin_state = 1'b1;
    w_regular   = 1'b0;
    w_ctx       = '0;
    w_set_x     = 1'b0;
    w_set_y     = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE_MVD: begin
        w_bin_state = 1'b0;
        if (mvd_start) w_next = GT0_X;
      end
      GT0_X: begin
        w_regular = 1'b1;
        w_ctx     = CTXIDX_ABS_MVD_GT0[r_init_idx];
        if (w_consume) w_next = GT0_Y;
      end
      GT0_Y: begin
        w_regular = 1'b1;
        w_ctx     = CTXIDX_ABS_MVD_GT0[r_init_idx];
        if (w_consume) w_next = r_gt0_x ? GT1_X : (ruiBin ? GT1_Y : DONE_MVD);
      end
      GT1_X: begin
        w_regular = 1'b1;
        w_ctx     = CTXIDX_ABS_MVD_GT1[r_init_idx];
        if (w_consume) w_next = r_gt0_y ? GT1_Y : (ruiBin ? EGP_X : SIGN_X);
      end
      GT1_Y: begin
        w_regular = 1'b1;
        w_ctx     = CTXIDX_ABS_MVD_GT1[r_init_idx];
        if (w_consume)
          w_next = r_gt0_x ? (r_gt1_x ? EGP_X : SIGN_X) : (ruiBin ? EGP_Y : SIGN_Y);
      end
      EGP_X, EGP_Y: begin
        if (w_ovf) begin
          w_err_set = 1'b1;
          w_next    = DONE_MVD;
        end else if (w_pre_done) begin
          w_next = (r_state == EGP_X) ? EGS_X : EGS_Y;
        end
      end
      EGS_X, EGS_Y: begin
        if (w_suf_done) w_next = (r_state == EGS_X) ? SIGN_X : SIGN_Y;
      end
      SIGN_X: begin
        if (w_consume) begin
          w_set_x = 1'b1;
          w_next  = r_gt0_y ? (r_gt1_y ? EGP_Y : SIGN_Y) : DONE_MVD;
        end
      end
      SIGN_Y: begin
        if (w_consume) begin
          w_set_y = 1'b1;
          w_next  = DONE_MVD;
        end
      end
      DONE_MVD: begin
        w_bin_state = 1'b0;
        w_next      = IDLE_MVD;
      end
      default: begin
        w_bin_state = 1'b0;
        w_next      = IDLE_MVD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= 1'b0;
      r_init_idx <= 1'b0;
      r_gt0_x    <= 1'b0;
      r_gt0_y    <= 1'b0;
      r_gt1_x    <= 1'b0;
      r_gt1_y    <= 1'b0;
      r_err      <= 1'b0;
      r_mvd_x    <= '0;
      r_mvd_y    <= '0;
    end else begin
      if (w_issue)        r_pending <= 1'b1;
      else if (w_consume) r_pending <= 1'b0;
      if (w_start_acc) begin
        r_init_idx <= init_set(slice_type, cabac_init_flag);
        r_gt0_x    <= 1'b0;
        r_gt0_y    <= 1'b0;
        r_gt1_x    <= 1'b0;
        r_gt1_y    <= 1'b0;
        r_err      <= 1'b0;
        r_mvd_x    <= '0;
        r_mvd_y    <= '0;
      end
      if (w_consume) begin
        case (r_state)
          GT0_X:   r_gt0_x <= ruiBin;
          GT0_Y:   r_gt0_y <= ruiBin;
          GT1_X:   r_gt1_x <= ruiBin;
          GT1_Y:   r_gt1_y <= ruiBin;
          default: ;
        endcase
      end
      if (w_set_x) r_mvd_x <= sat_mvd(w_abs_x, ruiBin);
      if (w_set_y) r_mvd_y <= sat_mvd(w_abs_y, ruiBin);
      if (w_err_set) begin
        r_err   <= 1'b1;
        r_mvd_x <= '0;
        r_mvd_y <= '0;
      end
    end
  end

  assign ctx_mvd_addr     = w_ctx;
  assign ctx_mvd_addr_vld = w_issue && w_regular;
  assign dec_run_mvd      = w_issue;
  assign EPMode_mvd       = w_issue && !w_regular;
  assign mvd_x            = r_mvd_x;
  assign mvd_y            = r_mvd_y;
  assign mvd_err          = r_err;
  assign mvd_done_intr    = (r_state == DONE_MVD);

endmodule

// File: tb/tb_qdec_mvd_syntax_fsm.sv
// tb/tb_qdec_mvd_syntax_fsm.sv - randomized scoreboard bench encoding MVDs into bins for the syntax FSM
module tb_qdec_mvd_syntax_fsm;

  localparam int MVD_W = 16;
  localparam logic [9:0] TB_GT0 [2] = '{10'd40, 10'd41};
  localparam logic [9:0] TB_GT1 [2] = '{10'd42, 10'd43};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mvd_start = 1'b0;
  logic [1:0] slice_type = 2'd0;
  logic cabac_init_flag = 1'b0;
  logic dec_rdy = 1'b0;
  logic ruiBin = 1'b0;
  logic ruiBin_vld = 1'b0;
  logic [9:0] ctx_mvd_addr;
  logic ctx_mvd_addr_vld, dec_run_mvd, EPMode_mvd, mvd_err, mvd_done_intr;
  logic signed [MVD_W-1:0] mvd_x, mvd_y;

  typedef struct { bit b; bit ep; logic [9:0] ctx; } bin_t;
  typedef struct { int x; int y; bit err; } exp_t;

  bin_t bq[$];
  exp_t expq[$];
  int n_checks = 0;
  int n_errors = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  int exp_done = 0;
  bit rdy_hold_low = 1'b0;
  bit stray_req = 1'b0;
  bit resp_busy = 1'b0;
  bit resp_drove = 1'b0;
  int resp_wait = 0;
  bin_t resp_e;
  bit prev_done = 1'b0;
  exp_t mon_e;

  always #5 clk = ~clk;

  qdec_mvd_syntax_fsm #(.MVD_W(MVD_W), .EG_MAX_PREFIX(15)) dut (
    .clk(clk), .rst_n(rst_n), .mvd_start(mvd_start), .slice_type(slice_type),
    .cabac_init_flag(cabac_init_flag), .ctx_mvd_addr(ctx_mvd_addr),
    .ctx_mvd_addr_vld(ctx_mvd_addr_vld), .dec_run_mvd(dec_run_mvd), .dec_rdy(dec_rdy),
    .EPMode_mvd(EPMode_mvd), .ruiBin(ruiBin), .ruiBin_vld(ruiBin_vld),
    .mvd_x(mvd_x), .mvd_y(mvd_y), .mvd_err(mvd_err), .mvd_done_intr(mvd_done_intr)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int a, input bit s);
    int v;
    if (a == 0) return 0;
    v = s ? -a : a;
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic push_bin(input bit b, input bit ep, input logic [9:0] c);
    bin_t t;
    t.b = b; t.ep = ep; t.ctx = c;
    bq.push_back(t);
  endtask

  // EG1 encoding of abs-2: prefix ones consume 2^k chunks, then k suffix bits MSB first
  task automatic push_eg(input int a);
    int n, k;
    n = a - 2;
    k = 1;
    while (n >= (1 << k)) begin
      push_bin(1'b1, 1'b1, 10'd0);
      n -= (1 << k);
      k++;
    end
    push_bin(1'b0, 1'b1, 10'd0);
    for (int i = k - 1; i >= 0; i--) push_bin(1'((n >> i) & 1), 1'b1, 10'd0);
  endtask

  // ovf: 0 normal, 1 prefix overflow on x, 2 prefix overflow on y
  task automatic start_txn(input int ax, input bit sx, input int ay, input bit sy, input int ovf);
    logic [1:0] st;
    bit cif;
    int it;
    exp_t e;
    st  = 2'($urandom_range(0, 3));
    cif = 1'($urandom_range(0, 1));
    it  = (st == 2'd1) ? (cif ? 2 : 1) : (cif ? 1 : 2);
    push_bin(ax != 0, 1'b0, TB_GT0[it-1]);
    push_bin(ay != 0, 1'b0, TB_GT0[it-1]);
    if (ax != 0) push_bin(ax > 1, 1'b0, TB_GT1[it-1]);
    if (ay != 0) push_bin(ay > 1, 1'b0, TB_GT1[it-1]);
    if (ovf == 1) begin
      repeat (15) push_bin(1'b1, 1'b1, 10'd0);
    end else begin
      if (ax > 1) push_eg(ax);
      if (ax != 0) push_bin(sx, 1'b1, 10'd0);
      if (ovf == 2) begin
        repeat (15) push_bin(1'b1, 1'b1, 10'd0);
      end else begin
        if (ay > 1) push_eg(ay);
        if (ay != 0) push_bin(sy, 1'b1, 10'd0);
      end
    end
    if (ovf != 0) begin
      e.x = 0; e.y = 0; e.err = 1'b1;
    end else begin
      e.x = sat(ax, sx); e.y = sat(ay, sy); e.err = 1'b0;
    end
    expq.push_back(e);
    exp_done++;
    @(negedge clk);
    slice_type = st;
    cabac_init_flag = cif;
    mvd_start = 1'b1;
    @(negedge clk);
    mvd_start = 1'b0;
    slice_type = 2'($urandom_range(0, 3));
    cabac_init_flag = 1'($urandom_range(0, 1));
    check("clear_on_start", longint'({mvd_x, mvd_y, mvd_err}), 0);
  endtask

  task automatic wait_done(input bit spur);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 4000 && !seen; t++) begin
      @(negedge clk);
      mvd_start = 1'b0;
      if (mvd_done_intr) seen = 1'b1;
      else if (spur && $urandom_range(0, 15) == 0) mvd_start = 1'b1;
    end
    mvd_start = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
      rst_n = 1'b0;
      expq.delete();
      bq.delete();
      @(negedge clk);
      exp_done = done_cnt;
      rst_n = 1'b1;
    end
  endtask

  initial begin : rdy_drive
    forever begin
      @(posedge clk);
      #1;
      dec_rdy = rdy_hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : responder
    forever begin
      @(negedge clk);
      if (resp_drove) begin
        ruiBin_vld = 1'b0;
        resp_drove = 1'b0;
      end
      if (!rst_n) begin
        resp_busy = 1'b0;
      end else if (resp_busy) begin
        if (resp_wait == 0) begin
          ruiBin = resp_e.b;
          ruiBin_vld = 1'b1;
          resp_drove = 1'b1;
          resp_busy = 1'b0;
        end else begin
          resp_wait--;
        end
      end else if (stray_req) begin
        ruiBin = 1'b1;
        ruiBin_vld = 1'b1;
        resp_drove = 1'b1;
        stray_req = 1'b0;
      end else if (dec_run_mvd) begin
        req_cnt++;
        if (bq.size() == 0) begin
          check("extra_request", 1, 0);
          resp_e.b = 1'b0;
        end else begin
          resp_e = bq.pop_front();
          check("ep_mode", longint'(EPMode_mvd), longint'(resp_e.ep));
          check("ctx_vld", longint'(ctx_mvd_addr_vld), longint'(!resp_e.ep));
          if (!resp_e.ep) check("ctx_addr", longint'(ctx_mvd_addr), longint'(resp_e.ctx));
        end
        resp_busy = 1'b1;
        resp_wait = $urandom_range(0, 3);
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && mvd_done_intr) begin
        done_cnt++;
        check("done_width", longint'(prev_done), 0);
        if (expq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = expq.pop_front();
          check("mvd_x", longint'(mvd_x), longint'(mon_e.x));
          check("mvd_y", longint'(mvd_y), longint'(mon_e.y));
          check("mvd_err", longint'(mvd_err), longint'(mon_e.err));
          check("bins_left", longint'(bq.size()), 0);
        end
      end
      prev_done = mvd_done_intr;
    end
  end

  initial begin : main
    int base, ax, ay;
    repeat (3) @(negedge clk);
    check("reset_outputs", longint'({mvd_x, mvd_y, mvd_err, mvd_done_intr, dec_run_mvd,
                                      ctx_mvd_addr_vld, EPMode_mvd, ctx_mvd_addr}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    start_txn(0, 0, 0, 0, 0);      wait_done(1'b0);
    start_txn(1, 0, 0, 0, 0);      wait_done(1'b0);
    start_txn(5, 1, 2, 0, 0);      wait_done(1'b0);
    start_txn(32767, 0, 32768, 1, 0); wait_done(1'b1);
    start_txn(65535, 0, 32769, 1, 0); wait_done(1'b1);
    start_txn(32768, 0, 65535, 1, 0); wait_done(1'b1);

    rdy_hold_low = 1'b1;
    repeat (2) @(negedge clk);
    start_txn(0, 0, 0, 0, 0);
    repeat (5) begin
      @(negedge clk);
      check("no_req_rdy_low", longint'(dec_run_mvd), 0);
    end
    stray_req = 1'b1;
    repeat (2) @(negedge clk);
    check("no_req_after_stray", longint'(dec_run_mvd), 0);
    rdy_hold_low = 1'b0;
    wait_done(1'b0);

    start_txn(40, 0, 0, 0, 1);     wait_done(1'b1);
    start_txn(37, 0, 9, 1, 2);     wait_done(1'b1);

    base = req_cnt;
    start_txn(5, 1, 2, 0, 0);
    for (int t = 0; t < 2000 && (req_cnt - base) < 7; t++) @(negedge clk);
    check("reach_egs_x", longint'((req_cnt - base) >= 7), 1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", longint'({mvd_x, mvd_y, mvd_err, mvd_done_intr, dec_run_mvd,
                                      ctx_mvd_addr_vld, EPMode_mvd, ctx_mvd_addr}), 0);
    void'(expq.pop_back());
    exp_done--;
    bq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_txn(3, 1, 0, 0, 0);      wait_done(1'b0);

    for (int n = 0; n < 150; n++) begin
      ax = 0; ay = 0;
      case ($urandom_range(0, 5))
        0: ax = 0;
        1: ax = 1;
        2: ax = $urandom_range(2, 10);
        3: ax = $urandom_range(2, 300);
        4: ax = $urandom_range(2, 40000);
        default: ax = $urandom_range(32766, 65535);
      endcase
      case ($urandom_range(0, 4))
        0: ay = 0;
        1: ay = 1;
        2: ay = $urandom_range(2, 20);
        3: ay = $urandom_range(2, 5000);
        default: ay = $urandom_range(2, 65535);
      endcase
      start_txn(ax, 1'($urandom_range(0, 1)), ay, 1'($urandom_range(0, 1)), 0);
      wait_done(1'b1);
    end

    repeat (4) @(negedge clk);
    check("done_count", longint'(done_cnt), longint'(exp_done));
    check("scoreboard_empty", longint'(expq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
